// File: rtl/axis_vlan_tag_decoder_qinq.sv
// Ingress VLAN classifier/stripper for 32-bit AXI-Stream frames with optional Q-in-Q parsing.
// Emits untagged frames with C-VLAN on tdest and S-VLAN on tid; keeps saturating frame counters.
module axis_vlan_tag_decoder_qinq #(
  parameter logic [15:0] CVLAN_TPID    = 16'h8100,
  parameter logic [15:0] SVLAN_TPID    = 16'h88a8,
  parameter bit          QINQ_ENABLE   = 1'b1,
  parameter int          COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              axi_rx_tdata,
  input  logic [3:0]               axi_rx_tkeep,
  input  logic                     axi_rx_tvalid,
  output logic                     axi_rx_tready,
  input  logic                     axi_rx_tlast,
  input  logic                     axi_rx_tuser,
  output logic [31:0]              axi_tx_tdata,
  output logic [3:0]               axi_tx_tkeep,
  output logic                     axi_tx_tvalid,
  input  logic                     axi_tx_tready,
  output logic                     axi_tx_tlast,
  output logic [11:0]              axi_tx_tid,
  output logic [11:0]              axi_tx_tdest,
  output logic                     axi_tx_tuser,
  input  logic [11:0]              port_vlan,
  input  logic [11:0]              vlan_min,
  input  logic [11:0]              vlan_max,
  input  logic                     drop_tagged,
  input  logic                     drop_untagged,
  output logic [COUNTER_WIDTH-1:0] frames_forwarded,
  output logic [COUNTER_WIDTH-1:0] frames_dropped
);

  typedef enum logic [2:0] {S_HDR, S_TAG1, S_TAG2, S_FLUSH, S_BODY, S_DROP} state_t;

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = {COUNTER_WIDTH{1'b1}};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic in_range(input logic [11:0] v, input logic [11:0] lo, input logic [11:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  state_t      state_r;
  logic [1:0]  hdr_cnt_r;
  logic [1:0]  flush_idx_r;
  logic [1:0]  flush_last_r;
  logic        end_in_flush_r;
  logic [31:0] buf_data_r [4];
  logic [3:0]  buf_keep_r [4];
  logic        acc_user_r;
  logic [11:0] cvid_r;
  logic [11:0] svid_r;
  logic [11:0] port_vlan_r;
  logic [11:0] vlan_min_r;
  logic [11:0] vlan_max_r;
  logic        drop_tagged_r;
  logic        drop_untagged_r;
  logic [31:0] tx_data_r;
  logic [3:0]  tx_keep_r;
  logic        tx_valid_r;
  logic        tx_last_r;
  logic [11:0] tx_tid_r;
  logic [11:0] tx_tdest_r;
  logic        tx_user_r;
  logic        fwd_pulse_r;
  logic        drop_pulse_r;
  logic [COUNTER_WIDTH-1:0] cnt_fwd_r;
  logic [COUNTER_WIDTH-1:0] cnt_drop_r;

  logic        rx_ready_s;
  logic        rx_fire_s;
  logic        load_ok_s;
  logic [15:0] tpid_s;
  logic [11:0] vid_s;
  logic [11:0] tag_cvid_s;
  logic        dec_drop_s;
  logic        dec_tag2_s;
  logic        dec_untag_s;
  logic [11:0] dec_cvid_s;
  logic [11:0] dec_svid_s;

  // TPID in bytes 0-1 of the tag beat, VID is the low 12 bits of the TCI in bytes 2-3
  assign tpid_s     = {axi_rx_tdata[7:0], axi_rx_tdata[15:8]};
  assign vid_s      = {axi_rx_tdata[19:16], axi_rx_tdata[31:24]};
  assign tag_cvid_s = (vid_s == 12'd0) ? port_vlan_r : vid_s;
  assign load_ok_s  = !tx_valid_r || axi_tx_tready;
  assign rx_fire_s  = axi_rx_tvalid && rx_ready_s;

  // Input backpressure: only FLUSH and a stalled BODY hold off the upstream MAC
  always_comb begin
    rx_ready_s = 1'b0;
    if (rst) begin
      rx_ready_s = 1'b0;
    end else begin
      case (state_r)
        S_HDR, S_TAG1, S_TAG2, S_DROP: rx_ready_s = 1'b1;
        S_FLUSH:                       rx_ready_s = 1'b0;
        S_BODY:                        rx_ready_s = load_ok_s;
        default:                       rx_ready_s = 1'b0;
      endcase
    end
  end

  // Classification of the current tag beat; only meaningful when a beat is accepted in TAG1/TAG2
  always_comb begin
    dec_drop_s  = 1'b0;
    dec_tag2_s  = 1'b0;
    dec_untag_s = 1'b0;
    dec_cvid_s  = port_vlan_r;
    dec_svid_s  = 12'd0;
    case (state_r)
      S_TAG1: begin
        if (tpid_s == CVLAN_TPID) begin
          dec_cvid_s = tag_cvid_s;
          dec_drop_s = (vid_s == 12'hfff) || drop_tagged_r || axi_rx_tlast ||
                       !in_range(tag_cvid_s, vlan_min_r, vlan_max_r);
        end else if ((tpid_s == SVLAN_TPID) && QINQ_ENABLE) begin
          dec_drop_s = (vid_s == 12'hfff) || axi_rx_tlast;
          dec_tag2_s = !((vid_s == 12'hfff) || axi_rx_tlast);
        end else begin
          dec_untag_s = 1'b1;
          dec_drop_s  = drop_untagged_r || !in_range(port_vlan_r, vlan_min_r, vlan_max_r);
        end
      end
      S_TAG2: begin
        dec_svid_s = svid_r;
        if (tpid_s == CVLAN_TPID) begin
          dec_cvid_s = tag_cvid_s;
          dec_drop_s = (vid_s == 12'hfff) || drop_tagged_r || axi_rx_tlast ||
                       !in_range(tag_cvid_s, vlan_min_r, vlan_max_r);
        end else begin
          dec_drop_s = 1'b1;
        end
      end
      default: begin
        dec_drop_s = 1'b0;
      end
    endcase
  end

  // Frame parser FSM with the registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= S_HDR;
      hdr_cnt_r       <= 2'd0;
      flush_idx_r     <= 2'd0;
      flush_last_r    <= 2'd0;
      end_in_flush_r  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        buf_data_r[i] <= 32'd0;
        buf_keep_r[i] <= 4'd0;
      end
      acc_user_r      <= 1'b0;
      cvid_r          <= 12'd0;
      svid_r          <= 12'd0;
      port_vlan_r     <= 12'd0;
      vlan_min_r      <= 12'd0;
      vlan_max_r      <= 12'd0;
      drop_tagged_r   <= 1'b0;
      drop_untagged_r <= 1'b0;
      tx_data_r       <= 32'd0;
      tx_keep_r       <= 4'd0;
      tx_valid_r      <= 1'b0;
      tx_last_r       <= 1'b0;
      tx_tid_r        <= 12'd0;
      tx_tdest_r      <= 12'd0;
      tx_user_r       <= 1'b0;
      fwd_pulse_r     <= 1'b0;
      drop_pulse_r    <= 1'b0;
    end else begin
      fwd_pulse_r  <= 1'b0;
      drop_pulse_r <= 1'b0;
      if (tx_valid_r && axi_tx_tready) begin
        tx_valid_r <= 1'b0;
      end
      case (state_r)
        S_HDR: begin
          if (rx_fire_s) begin
            buf_data_r[hdr_cnt_r] <= axi_rx_tdata;
            buf_keep_r[hdr_cnt_r] <= axi_rx_tkeep;
            if (hdr_cnt_r == 2'd0) begin
              port_vlan_r     <= port_vlan;
              vlan_min_r      <= vlan_min;
              vlan_max_r      <= vlan_max;
              drop_tagged_r   <= drop_tagged;
              drop_untagged_r <= drop_untagged;
              acc_user_r      <= axi_rx_tuser;
            end else begin
              acc_user_r      <= acc_user_r | axi_rx_tuser;
            end
            if (axi_rx_tlast) begin
              drop_pulse_r <= 1'b1;
              hdr_cnt_r    <= 2'd0;
            end else if (hdr_cnt_r == 2'd2) begin
              hdr_cnt_r    <= 2'd0;
              state_r      <= S_TAG1;
            end else begin
              hdr_cnt_r    <= hdr_cnt_r + 2'd1;
            end
          end
        end
        S_TAG1, S_TAG2: begin
          if (rx_fire_s) begin
            acc_user_r <= acc_user_r | axi_rx_tuser;
            if (dec_drop_s) begin
              drop_pulse_r <= 1'b1;
              state_r      <= axi_rx_tlast ? S_HDR : S_DROP;
            end else if (dec_tag2_s) begin
              svid_r  <= vid_s;
              state_r <= S_TAG2;
            end else begin
              fwd_pulse_r    <= 1'b1;
              cvid_r         <= dec_cvid_s;
              svid_r         <= dec_svid_s;
              buf_data_r[3]  <= axi_rx_tdata;
              buf_keep_r[3]  <= axi_rx_tkeep;
              flush_last_r   <= dec_untag_s ? 2'd3 : 2'd2;
              end_in_flush_r <= axi_rx_tlast;
              state_r        <= S_FLUSH;
              // Launch the first buffered word now so output starts the very next cycle
              if (load_ok_s) begin
                tx_data_r   <= buf_data_r[0];
                tx_keep_r   <= buf_keep_r[0];
                tx_valid_r  <= 1'b1;
                tx_last_r   <= 1'b0;
                tx_user_r   <= 1'b0;
                tx_tid_r    <= dec_svid_s;
                tx_tdest_r  <= dec_cvid_s;
                flush_idx_r <= 2'd1;
              end else begin
                flush_idx_r <= 2'd0;
              end
            end
          end
        end
        S_FLUSH: begin
          if (load_ok_s) begin
            tx_data_r  <= buf_data_r[flush_idx_r];
            tx_keep_r  <= buf_keep_r[flush_idx_r];
            tx_valid_r <= 1'b1;
            tx_last_r  <= end_in_flush_r && (flush_idx_r == flush_last_r);
            tx_user_r  <= end_in_flush_r && (flush_idx_r == flush_last_r) && acc_user_r;
            tx_tid_r   <= svid_r;
            tx_tdest_r <= cvid_r;
            if (flush_idx_r == flush_last_r) begin
              state_r <= end_in_flush_r ? S_HDR : S_BODY;
            end else begin
              flush_idx_r <= flush_idx_r + 2'd1;
            end
          end
        end
        S_BODY: begin
          if (rx_fire_s) begin
            tx_data_r  <= axi_rx_tdata;
            tx_keep_r  <= axi_rx_tkeep;
            tx_valid_r <= 1'b1;
            tx_last_r  <= axi_rx_tlast;
            tx_user_r  <= axi_rx_tlast && (acc_user_r | axi_rx_tuser);
            tx_tid_r   <= svid_r;
            tx_tdest_r <= cvid_r;
            acc_user_r <= acc_user_r | axi_rx_tuser;
            if (axi_rx_tlast) begin
              state_r <= S_HDR;
            end
          end
        end
        S_DROP: begin
          if (rx_fire_s && axi_rx_tlast) begin
            state_r <= S_HDR;
          end
        end
        default: begin
          state_r <= S_HDR;
        end
      endcase
    end
  end

  // Saturating statistics, updated the cycle after each frame decision
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_fwd_r  <= {COUNTER_WIDTH{1'b0}};
      cnt_drop_r <= {COUNTER_WIDTH{1'b0}};
    end else begin
      if (fwd_pulse_r && (cnt_fwd_r != CNT_MAX)) begin
        cnt_fwd_r <= cnt_fwd_r + CNT_ONE;
      end
      if (drop_pulse_r && (cnt_drop_r != CNT_MAX)) begin
        cnt_drop_r <= cnt_drop_r + CNT_ONE;
      end
    end
  end

  assign axi_rx_tready    = rx_ready_s;
  assign axi_tx_tdata     = tx_data_r;
  assign axi_tx_tkeep     = tx_keep_r;
  assign axi_tx_tvalid    = tx_valid_r;
  assign axi_tx_tlast     = tx_last_r;
  assign axi_tx_tid       = tx_tid_r;
  assign axi_tx_tdest     = tx_tdest_r;
  assign axi_tx_tuser     = tx_user_r;
  assign frames_forwarded = cnt_fwd_r;
  assign frames_dropped   = cnt_drop_r;

endmodule

// File: tb/tb_axis_vlan_tag_decoder_qinq.sv
// Scoreboard bench: a Q-in-Q instance (32-bit counters) and a single-tag-only instance (2-bit counters)
// share one stimulus port; sel chooses which one is driven and observed.
module tb_axis_vlan_tag_decoder_qinq;

  typedef struct packed {
    logic        user;
    logic        last;
    logic [11:0] tid;
    logic [11:0] tdest;
    logic [3:0]  keep;
    logic [31:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic [31:0] rx_tdata = 32'd0;
  logic [3:0]  rx_tkeep = 4'hf;
  logic        rx_tvalid = 1'b0;
  logic        rx_tlast = 1'b0;
  logic        rx_tuser = 1'b0;
  logic        tx_tready;
  logic [11:0] port_vlan = 12'd42;
  logic [11:0] vlan_min = 12'd1;
  logic [11:0] vlan_max = 12'd4094;
  logic        drop_tagged = 1'b0;
  logic        drop_untagged = 1'b0;

  logic        rdy1, rdy0, v1, v0, l1, l0, u1, u0;
  logic [31:0] d1, d0;
  logic [3:0]  k1, k0;
  logic [11:0] id1, id0, de1, de0;
  logic [31:0] ff1, fd1;
  logic [1:0]  ff0, fd0;

  wire rx_tready_m = sel ? rdy0 : rdy1;
  wire m_valid = sel ? v0 : v1;
  wire [61:0] m_beat = sel ? {u0, l0, id0, de0, k0, d0} : {u1, l1, id1, de1, k1, d1};

  axis_vlan_tag_decoder_qinq #(.QINQ_ENABLE(1'b1), .COUNTER_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .axi_rx_tdata(rx_tdata), .axi_rx_tkeep(rx_tkeep), .axi_rx_tvalid(rx_tvalid & !sel),
    .axi_rx_tready(rdy1), .axi_rx_tlast(rx_tlast), .axi_rx_tuser(rx_tuser),
    .axi_tx_tdata(d1), .axi_tx_tkeep(k1), .axi_tx_tvalid(v1), .axi_tx_tready(tx_tready),
    .axi_tx_tlast(l1), .axi_tx_tid(id1), .axi_tx_tdest(de1), .axi_tx_tuser(u1),
    .port_vlan(port_vlan), .vlan_min(vlan_min), .vlan_max(vlan_max),
    .drop_tagged(drop_tagged), .drop_untagged(drop_untagged),
    .frames_forwarded(ff1), .frames_dropped(fd1));

  axis_vlan_tag_decoder_qinq #(.QINQ_ENABLE(1'b0), .COUNTER_WIDTH(2)) dut_noq (
    .clk(clk), .rst(rst),
    .axi_rx_tdata(rx_tdata), .axi_rx_tkeep(rx_tkeep), .axi_rx_tvalid(rx_tvalid & sel),
    .axi_rx_tready(rdy0), .axi_rx_tlast(rx_tlast), .axi_rx_tuser(rx_tuser),
    .axi_tx_tdata(d0), .axi_tx_tkeep(k0), .axi_tx_tvalid(v0), .axi_tx_tready(tx_tready),
    .axi_tx_tlast(l0), .axi_tx_tid(id0), .axi_tx_tdest(de0), .axi_tx_tuser(u0),
    .port_vlan(port_vlan), .vlan_min(vlan_min), .vlan_max(vlan_max),
    .drop_tagged(drop_tagged), .drop_untagged(drop_untagged),
    .frames_forwarded(ff0), .frames_dropped(fd0));

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass = 0;
  int    n_fail = 0;
  int    rmode = 0;
  bit    ignore_out = 1'b0;
  int    e_fwd1 = 0, e_drop1 = 0, e_fwd0 = 0, e_drop0 = 0;
  beat_t exp_q[$];
  logic [31:0] fw[$];
  logic        fu[$];
  logic [3:0]  klast = 4'hf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tagword(input logic [15:0] tpid, input logic [15:0] tci);
    return {tci[7:0], tci[15:8], tpid[7:0], tpid[15:8]};
  endfunction

  // kind: 0 untagged, 1 C-tag, 2 S-tag + C-tag, 3 S-tag + non-C inner
  task automatic build(input int kind, input logic [11:0] va, input logic [11:0] vb, input int n);
    logic [31:0] w;
    fw.delete();
    fu.delete();
    klast = 4'hf;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (i == 3) begin
        case (kind)
          1:       w = tagword(16'h8100, {4'ha, va});
          2, 3:    w = tagword(16'h88a8, {4'h3, va});
          default: w = {w[31:16], 16'h0008};
        endcase
      end else if (i == 4 && kind == 2) begin
        w = tagword(16'h8100, {4'h5, vb});
      end else if (i == 4 && kind == 3) begin
        w = {w[31:16], 16'h0008};
      end
      fw.push_back(w);
      fu.push_back(1'b0);
    end
  endtask

  // Reference behaviour: pushes expected output beats, returns 1 when the frame is forwarded
  function automatic bit model(input bit qinq);
    int n, s_lo, s_hi;
    logic [31:0] w3, w4;
    logic [15:0] t1, t2, c1, c2;
    logic [11:0] cv, sv;
    bit drop;
    logic anyu;
    beat_t b;
    n = fw.size();
    cv = port_vlan;
    sv = 12'd0;
    s_lo = 3;
    s_hi = 2;
    if (n < 4) return 1'b0;
    w3 = fw[3];
    t1 = {w3[7:0], w3[15:8]};
    c1 = {w3[23:16], w3[31:24]};
    if (t1 == 16'h8100) begin
      cv = (c1[11:0] == 12'd0) ? port_vlan : c1[11:0];
      drop = (c1[11:0] == 12'hfff) || drop_tagged || (n == 4);
      s_hi = 3;
    end else if (t1 == 16'h88a8 && qinq) begin
      if (n < 5) return 1'b0;
      w4 = fw[4];
      t2 = {w4[7:0], w4[15:8]};
      c2 = {w4[23:16], w4[31:24]};
      if (t2 != 16'h8100) return 1'b0;
      sv = c1[11:0];
      cv = (c2[11:0] == 12'd0) ? port_vlan : c2[11:0];
      drop = (c1[11:0] == 12'hfff) || (c2[11:0] == 12'hfff) || drop_tagged || (n == 5);
      s_hi = 4;
    end else begin
      drop = drop_untagged;
    end
    if (drop || cv < vlan_min || cv > vlan_max) return 1'b0;
    anyu = 1'b0;
    foreach (fu[i]) anyu = anyu | fu[i];
    for (int i = 0; i < n; i++) begin
      if (i < s_lo || i > s_hi) begin
        b.data  = fw[i];
        b.keep  = (i == n - 1) ? klast : 4'hf;
        b.last  = (i == n - 1);
        b.user  = (i == n - 1) && anyu;
        b.tid   = sv;
        b.tdest = cv;
        exp_q.push_back(b);
      end
    end
    return 1'b1;
  endfunction

  task automatic send_frame(input int upto);
    int n, t;
    bit hs;
    n = fw.size();
    for (int i = 0; i < upto; i++) begin
      rx_tdata  = fw[i];
      rx_tkeep  = (i == n - 1) ? klast : 4'hf;
      rx_tlast  = (i == n - 1);
      rx_tuser  = fu[i];
      rx_tvalid = 1'b1;
      hs = 1'b0;
      t = 0;
      while (!hs && t < 1000) begin
        @(negedge clk);
        hs = rx_tready_m;
        @(posedge clk);
        #1;
        t++;
      end
      if (!hs) chk("rx_handshake_timeout", 64'(hs), 64'd1);
    end
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
    rx_tuser  = 1'b0;
  endtask

  task automatic run_frame();
    bit f;
    f = model(!sel);
    if (sel) begin
      if (f) e_fwd0++; else e_drop0++;
    end else begin
      if (f) e_fwd1++; else e_drop1++;
    end
    send_frame(fw.size());
  endtask

  task automatic check_counters();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("fwd_cnt_qinq", 64'(ff1), 64'(e_fwd1));
    chk("drop_cnt_qinq", 64'(fd1), 64'(e_drop1));
    chk("fwd_cnt_noq", 64'(ff0), 64'((e_fwd0 > 3) ? 3 : e_fwd0));
    chk("drop_cnt_noq", 64'(fd0), 64'((e_drop0 > 3) ? 3 : e_drop0));
  endtask

  function automatic logic [11:0] pick_vid();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 12'd0;
    if (r == 1) return 12'hfff;
    if (r == 2) return 12'($urandom_range(3001, 4094));
    return 12'($urandom_range(1, 3000));
  endfunction

  // Downstream ready: 0 = always, 1 = random 50%, 2 = stalled
  initial begin
    tx_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       tx_tready = 1'b1;
        1:       tx_tready = 1'($urandom_range(0, 1));
        default: tx_tready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor: every output handshake pops and compares one expected beat
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!ignore_out && !rst && m_valid && tx_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 64'(m_beat), 64'(e));
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_tready", 64'(rx_tready_m), 64'd0);
    chk("rst_tvalid", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_regs", 64'(m_beat), 64'd0);
    chk("rst_counters", {ff1, fd1}, 64'd0);
    chk("hdr_rx_tready", 64'(rx_tready_m), 64'd1);
    @(posedge clk);
    #1;

    build(1, 12'd100, 12'd0, 16); run_frame(); check_counters();
    build(0, 12'd0, 12'd0, 16); run_frame();
    drop_untagged = 1'b1;
    build(0, 12'd0, 12'd0, 16); run_frame(); check_counters();
    drop_untagged = 1'b0;
    build(2, 12'd7, 12'd300, 16); run_frame(); check_counters();

    sel = 1'b1;
    run_frame();
    check_counters();
    build(0, 12'd0, 12'd0, 6); run_frame();
    build(1, 12'd9, 12'd0, 7); run_frame();
    build(0, 12'd0, 12'd0, 5); run_frame();
    check_counters();
    sel = 1'b0;
    @(posedge clk);
    #1;

    build(1, 12'd0, 12'd0, 8); run_frame();
    build(1, 12'hfff, 12'd0, 8); run_frame();
    vlan_max = 12'd400;
    build(1, 12'd500, 12'd0, 8); run_frame();
    build(1, 12'd400, 12'd0, 8); run_frame();
    vlan_max = 12'd4094;
    build(2, 12'hfff, 12'd5, 8); run_frame();
    build(3, 12'd5, 12'd0, 8); run_frame();
    drop_tagged = 1'b1;
    build(1, 12'd10, 12'd0, 8); run_frame();
    drop_tagged = 1'b0;
    check_counters();

    build(1, 12'd11, 12'd0, 3); run_frame();
    build(1, 12'd5, 12'd0, 10); fu[6] = 1'b1; run_frame();
    build(0, 12'd0, 12'd0, 4); klast = 4'h3; fu[1] = 1'b1; run_frame();
    build(1, 12'd12, 12'd0, 4); run_frame();
    build(2, 12'd12, 12'd13, 5); run_frame();
    build(2, 12'd12, 12'd13, 4); run_frame();
    check_counters();

    rmode = 1;
    vlan_max = 12'd3000;
    for (int f = 0; f < 100; f++) begin
      int k, n, ui;
      k = $urandom_range(0, 3);
      n = $urandom_range(2, 12);
      drop_tagged = ($urandom_range(0, 9) == 0);
      drop_untagged = ($urandom_range(0, 9) == 0);
      build(k, pick_vid(), pick_vid(), n);
      klast = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) begin
        ui = $urandom_range(0, n - 1);
        fu[ui] = 1'b1;
      end
      run_frame();
    end
    check_counters();
    rmode = 0;
    drop_tagged = 1'b0;
    drop_untagged = 1'b0;
    vlan_max = 12'd4094;

    rmode = 2;
    @(posedge clk);
    #1;
    ignore_out = 1'b1;
    build(1, 12'd77, 12'd0, 10);
    send_frame(4);
    @(negedge clk);
    chk("stalled_tvalid", 64'(m_valid), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midframe_rst_tvalid", 64'(m_valid), 64'd0);
    exp_q.delete();
    e_fwd1 = 0; e_drop1 = 0; e_fwd0 = 0; e_drop0 = 0;
    ignore_out = 1'b0;
    rmode = 0;
    @(posedge clk);
    #1;
    build(2, 12'd21, 12'd22, 9); run_frame();
    check_counters();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
